// File: rtl/quiz_pkg.sv
// Shared definitions for the quiz round controller: FSM encoding, player count,
// and the lowest-index-wins priority encoder used to pick a buzzer winner.
package quiz_pkg;

  localparam int NUM_PLAYERS = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    LOCK      = 3'd2,
    TIMEOUT   = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Lowest set bit wins, so simultaneous buzzers resolve deterministically.
  function automatic logic [1:0] first_player(input logic [NUM_PLAYERS-1:0] v);
    first_player = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (v[i]) first_player = i[1:0];
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, and a one-cycle pulse
// on every accepted 0->1 transition of the debounced level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic rise
);

  localparam int               CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  // NOTE: every register here uses non-blocking assignment so the two synchroniser
  // stages shift on the same edge instead of collapsing into a single flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      rise   <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // The new value has been seen for DEB_CYCLES consecutive samples.
        level_q <= sync_q[1];
        cnt_q   <= '0;
        rise    <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz round controller: drives the sweep timer's st line, locks the first buzzer
// in each round, keeps saturating per-player scores and ends the game after ROUNDS.
module quiz_round_ctrl
  import quiz_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int ROUNDS     = 3,
  parameter int SCORE_W    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_start,
  input  logic [3:0]               btn_player,
  input  logic                     time_end,
  output logic                     st,
  output logic [1:0]               winner,
  output logic                     winner_valid,
  output logic                     timeout,
  output logic [3:0]               round,
  output logic [4*SCORE_W-1:0]     scores,
  output logic                     game_over
);

  localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic                                start_pulse;
  logic [NUM_PLAYERS-1:0]              player_pulse;
  logic [1:0]                          pick;
  state_t                              state;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start_deb (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_start),
    .rise (start_pulse)
  );

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_player_deb (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_player[i]),
      .rise (player_pulse[i])
    );
  end

  assign pick   = first_player(player_pulse);
  assign scores = score_q;

  // NOTE: the score registers are plain flops, not a memory, so they are cleared by
  // the asynchronous reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      st           <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      round        <= '0;
      score_q      <= '0;
      game_over    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_pulse) begin
            state <= RUN;
            st    <= 1'b1;
          end
        end

        RUN: begin
          // A buzzer in the same cycle as time_end still wins the round.
          if (|player_pulse) begin
            state        <= LOCK;
            st           <= 1'b0;
            winner       <= pick;
            winner_valid <= 1'b1;
            round        <= round + 4'd1;
            if (score_q[pick] != SCORE_MAX) begin
              score_q[pick] <= score_q[pick] + SCORE_W'(1);
            end
          end else if (time_end) begin
            state   <= TIMEOUT;
            st      <= 1'b0;
            timeout <= 1'b1;
            round   <= round + 4'd1;
          end
        end

        LOCK, TIMEOUT: begin
          if (round == LAST_ROUND) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
          end else if (start_pulse) begin
            state        <= RUN;
            st           <= 1'b1;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
          end
        end

        GAME_OVER: begin
          // Last-round result stays visible until the host starts a new game.
          if (start_pulse) begin
            state        <= IDLE;
            game_over    <= 1'b0;
            winner       <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            round        <= '0;
            score_q      <= '0;
          end
        end

        default: begin
          state <= IDLE;
          st    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed bench for quiz_round_ctrl with a behavioural sweep timer per DUT instance.
module tb_quiz_round_ctrl;

  localparam int DEB    = 4;
  localparam int ROUNDS = 3;
  localparam int LAT    = DEB + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic [3:0]  btn_player = '0;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;

  logic        te1_model, te1;
  logic        st1, wv1, to1, go1;
  logic [1:0]  win1;
  logic [3:0]  round1;
  logic [15:0] scores1;

  logic        te2;
  logic        st2, wv2, to2, go2;
  logic [1:0]  win2;
  logic [3:0]  round2;
  logic [11:0] scores2;

  int errors = 0;
  int checks = 0;
  logic [25:0] obs1, expv;
  logic [21:0] obs2, exp2;

  assign te1  = force_en ? force_val : te1_model;
  assign obs1 = {st1, wv1, win1, to1, go1, round1, scores1};
  assign obs2 = {st2, wv2, win2, to2, go2, round2, scores2};

  quiz_round_ctrl #(.DEB_CYCLES(DEB), .ROUNDS(ROUNDS), .SCORE_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .btn_player   (btn_player),
    .time_end     (te1),
    .st           (st1),
    .winner       (win1),
    .winner_valid (wv1),
    .timeout      (to1),
    .round        (round1),
    .scores       (scores1),
    .game_over    (go1)
  );

  // Narrow scores and a long game so saturation is reachable within one game.
  quiz_round_ctrl #(.DEB_CYCLES(DEB), .ROUNDS(15), .SCORE_W(3)) dut_sat (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btn_start),
    .btn_player   (btn_player),
    .time_end     (te2),
    .st           (st2),
    .winner       (win2),
    .winner_valid (wv2),
    .timeout      (to2),
    .round        (round2),
    .scores       (scores2),
    .game_over    (go2)
  );

  always #5 clk = ~clk;

  // Sweep timer model: held while st=0, time_end rises 50 cycles after st rises.
  int cnt1, cnt2;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt1 <= 0; te1_model <= 1'b0;
    end else if (!st1) begin
      cnt1 <= 0; te1_model <= 1'b0;
    end else if (cnt1 == 49) te1_model <= 1'b1;
    else cnt1 <= cnt1 + 1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt2 <= 0; te2 <= 1'b0;
    end else if (!st2) begin
      cnt2 <= 0; te2 <= 1'b0;
    end else if (cnt2 == 49) te2 <= 1'b1;
    else cnt2 <= cnt2 + 1;
  end

  function automatic logic [25:0] pack1(input logic s, input logic wv, input logic [1:0] w,
                                        input logic to, input logic go, input logic [3:0] r,
                                        input logic [15:0] sc);
    return {s, wv, w, to, go, r, sc};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; btn_start = 1'b0; btn_player = '0; force_en = 1'b0; force_val = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  // Full press/release; the FSM reacts on the (LAT+1)-th tick.
  task automatic press_start();
    btn_start = 1'b1; tick(LAT + 1);
    btn_start = 1'b0; tick(LAT + 1);
  endtask

  task automatic press_player(input logic [3:0] m);
    btn_player = m; tick(LAT + 1);
    btn_player = '0; tick(LAT + 1);
  endtask

  task automatic wait_time_end(input string name);
    for (int i = 0; i < 100 && te1 !== 1'b1; i++) tick(1);
    checks++;
    if (te1 !== 1'b1) begin
      errors++; $display("FAIL %s: time_end got %b expected 1 within 100 cycles", name, te1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_start = 1'b1; btn_player = 4'hF;
    tick(3);
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs1, 26'h0);
    end
    btn_start = 1'b0; btn_player = '0;
    rst = 1'b1;
    tick(2);
  endtask

  task automatic test_round_win();
    do_reset();
    btn_start = 1'b1; tick(LAT);
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL idle_before_start: got %h expected %h", obs1, 26'h0);
    end
    tick(1);
    expv = pack1(1, 0, 0, 0, 0, 0, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL run_entry: got %h expected %h", obs1, expv);
    end
    btn_start = 1'b0; tick(19);
    btn_player = 4'b0100; tick(LAT);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL pre_lock: got %h expected %h", obs1, expv);
    end
    tick(1);
    expv = pack1(0, 1, 2'd2, 0, 0, 4'd1, 16'h0100);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL lock_p2: got %h expected %h", obs1, expv);
    end
    btn_player = '0; tick(LAT + 1);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL lock_hold: got %h expected %h", obs1, expv);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    press_start();
    wait_time_end("timeout_bound");
    expv = pack1(1, 0, 0, 0, 0, 0, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL run_at_time_end: got %h expected %h", obs1, expv);
    end
    tick(1);
    expv = pack1(0, 0, 0, 1, 0, 4'd1, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL timeout: got %h expected %h", obs1, expv);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    press_start();
    force_en = 1'b1; force_val = 1'b0;
    btn_player = 4'b1010; tick(LAT);
    force_val = 1'b1; tick(1);
    expv = pack1(0, 1, 2'd1, 0, 0, 4'd1, 16'h0010);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL press_beats_time_end: got %h expected %h", obs1, expv);
    end
    btn_player = '0; force_en = 1'b0; tick(LAT + 1);
  endtask

  task automatic test_glitch();
    do_reset();
    press_start();
    btn_player = 4'b0001; tick(3);
    btn_player = '0; tick(12);
    expv = pack1(1, 0, 0, 0, 0, 0, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL glitch_ignored: got %h expected %h", obs1, expv);
    end
    wait_time_end("glitch_bound");
    tick(1);
    btn_player = 4'b0001; tick(LAT + 1);
    expv = pack1(0, 0, 0, 1, 0, 4'd1, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL press_outside_run: got %h expected %h", obs1, expv);
    end
    btn_player = '0; tick(LAT + 1);
    btn_start = 1'b1; tick(LAT + 1);
    btn_start = 1'b0; tick(2);
    expv = pack1(1, 0, 0, 0, 0, 4'd1, 16'h0000);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL no_queued_press: got %h expected %h", obs1, expv);
    end
  endtask

  task automatic test_game();
    do_reset();
    press_start();
    press_player(4'b0001);
    expv = pack1(0, 1, 2'd0, 0, 0, 4'd1, 16'h0001);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL game_r1: got %h expected %h", obs1, expv);
    end
    press_start();
    wait_time_end("game_r2_bound");
    tick(1);
    expv = pack1(0, 0, 2'd0, 1, 0, 4'd2, 16'h0001);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL game_r2: got %h expected %h", obs1, expv);
    end
    press_start();
    btn_player = 4'b0001; tick(LAT + 1);
    expv = pack1(0, 1, 2'd0, 0, 0, 4'd3, 16'h0002);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL game_r3_lock: got %h expected %h", obs1, expv);
    end
    tick(1);
    expv = pack1(0, 1, 2'd0, 0, 1, 4'd3, 16'h0002);
    checks++;
    if (obs1 !== expv) begin
      errors++; $display("FAIL game_over: got %h expected %h", obs1, expv);
    end
    btn_player = '0; tick(LAT + 1);
    btn_start = 1'b1; tick(LAT + 1);
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL back_to_idle: got %h expected %h", obs1, 26'h0);
    end
    btn_start = 1'b0; tick(LAT + 1);
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL idle_hold: got %h expected %h", obs1, 26'h0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_start();
    btn_start = 1'b1; btn_player = 4'hF;
    rst = 1'b0; #1;
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL async_reset: got %h expected %h", obs1, 26'h0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (st1 !== 1'b0) begin
        errors++; $display("FAIL reset_hold_st: cycle %0d got %b expected 0", i, st1);
      end
    end
    btn_start = 1'b0; btn_player = '0;
    rst = 1'b1; tick(LAT + 2);
    checks++;
    if (obs1 !== '0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected %h", obs1, 26'h0);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int r = 1; r <= 15; r++) begin
      press_start();
      press_player(4'b1000);
      if (r == 7 || r == 8) begin
        checks++;
        if (scores2[11:9] !== 3'd7) begin
          errors++; $display("FAIL sat_p3_round%0d: got %0d expected 7", r, scores2[11:9]);
        end
      end
    end
    exp2 = {1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 4'd15, 12'hE00};
    checks++;
    if (obs2 !== exp2) begin
      errors++; $display("FAIL sat_game_over: got %h expected %h", obs2, exp2);
    end
  endtask

  initial begin
    test_reset();
    test_round_win();
    test_timeout();
    test_simultaneous();
    test_glitch();
    test_game();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
